istft_ola: RTL and testbench

- Synthesis end of the STFT path: takes frames of time-domain samples from the inverse FFT and reconstructs a continuous sample stream by overlap-add with hop HOP_SIZE.
- Per frame: the first HOP_SIZE samples are completed and emitted; the remaining samples are accumulated into a circular buffer for later frames.
- Sits after the IFFT/synthesis-window stage. It is the inverse counterpart of the delay-buffer/framing front end.

---
 rtl/istft_ola.sv | 151 +++++++++++++++
 tb/tb_istft_ola.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/istft_ola.sv
// istft_ola: overlap-add reconstruction of IFFT frames with hop HOP_SIZE into a sample stream.
// Optional ISTFT_SAT_EN: saturate the shifted sum to OW bits instead of wrapping.
module istft_ola #(
    parameter int IW       = 18,
    parameter int OW       = 16,
    parameter int FFT_SIZE = 256,
    parameter int HOP_SIZE = 128,
    parameter int SHIFT    = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic                 i_sync,
    input  logic signed [IW-1:0] i_sample,
    output logic                 o_ready,
    output logic                 o_ce,
    output logic signed [OW-1:0] o_sample,
    output logic                 o_sync,
    output logic                 o_frame_err
);
    localparam int LGN = $clog2(FFT_SIZE);
    localparam int LGR = $clog2(FFT_SIZE / HOP_SIZE);
    localparam int AW  = IW + LGR;
    localparam logic [LGN-1:0] HOP  = LGN'(HOP_SIZE);
    localparam logic [LGN-1:0] LAST = LGN'(FFT_SIZE - 1);
    localparam logic [LGN-1:0] TAIL = LGN'(FFT_SIZE - HOP_SIZE);

    typedef enum logic [1:0] {CLEAR, WAIT_SYNC, RUN} state_t;
    typedef enum logic [1:0] {RG_EMIT, RG_ACC, RG_OVR} region_t;

    state_t  state, state_nxt;
    region_t rg, s1_rg;

    logic [LGN-1:0] clr_addr, base, idx, base_eff, idx_eff, rd_addr, s1_addr, wa;
    logic           take, misalign, clr_we, s1_vld, s1_first, we, emit;

    logic signed [AW-1:0] mem [FFT_SIZE];
    logic signed [AW-1:0] rd_q, s1_x, sum, shf, wd;
    logic signed [OW-1:0] cvt;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= CLEAR;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:     if (clr_addr == LAST) state_nxt = WAIT_SYNC;
            WAIT_SYNC: if (i_ce && i_sync)   state_nxt = RUN;
            RUN:       state_nxt = RUN;
            default:   state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        o_ready = (state != CLEAR);
        clr_we  = (state == CLEAR);
    end

    // A misaligned sync closes the current frame early and starts a new one a hop later.
    always_comb begin
        take     = 1'b0;
        misalign = 1'b0;
        base_eff = base;
        idx_eff  = idx;
        if (state == WAIT_SYNC && i_ce && i_sync) begin
            take     = 1'b1;
            base_eff = '0;
            idx_eff  = '0;
        end else if (state == RUN && i_ce) begin
            take = 1'b1;
            if (i_sync && idx != '0) begin
                misalign = 1'b1;
                base_eff = base + HOP;
                idx_eff  = '0;
            end
        end
        rd_addr = base_eff + idx_eff;
        if (idx_eff < HOP)        rg = RG_EMIT;
        else if (idx_eff >= TAIL) rg = RG_OVR;
        else                      rg = RG_ACC;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clr_addr    <= '0;
            base        <= '0;
            idx         <= '0;
            s1_vld      <= 1'b0;
            o_ce        <= 1'b0;
            o_sync      <= 1'b0;
            o_frame_err <= 1'b0;
            o_sample    <= '0;
        end else begin
            if (clr_we) clr_addr <= clr_addr + 1'b1;
            if (take) begin
                idx  <= idx_eff + 1'b1;
                base <= (idx_eff == LAST) ? base_eff + HOP : base_eff;
            end
            s1_vld      <= take;
            o_frame_err <= misalign;
            o_ce        <= emit;
            o_sync      <= emit && s1_first;
            if (emit) o_sample <= cvt;
        end
    end

    always_ff @(posedge i_clk) begin
        s1_addr  <= rd_addr;
        s1_x     <= AW'(i_sample);
        s1_rg    <= rg;
        s1_first <= (idx_eff == '0);
    end

    // Read-old-data RAM; frame geometry keeps reads and writes of one address apart.
    always_ff @(posedge i_clk) begin
        if (we) mem[wa] <= wd;
        rd_q <= mem[rd_addr];
    end

`ifdef ISTFT_SAT_EN
    localparam int EW = AW + OW;
    localparam logic signed [EW-1:0] SAT_HI = {{(AW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {{(AW+1){1'b1}}, {(OW-1){1'b0}}};
    logic signed [EW-1:0] ext;
`endif

    always_comb begin
        emit = s1_vld && (s1_rg == RG_EMIT);
        sum  = rd_q + s1_x;
        shf  = sum >>> SHIFT;
`ifdef ISTFT_SAT_EN
        ext = EW'(shf);
        if (ext > SAT_HI)      cvt = OW'(SAT_HI);
        else if (ext < SAT_LO) cvt = OW'(SAT_LO);
        else                   cvt = OW'(ext);
`else
        cvt = OW'(shf);
`endif
        if (clr_we) begin
            we = 1'b1;
            wa = clr_addr;
            wd = '0;
        end else begin
            we = s1_vld && (s1_rg != RG_EMIT);
            wa = s1_addr;
            wd = (s1_rg == RG_ACC) ? sum : s1_x;
        end
    end
endmodule

// File: tb/tb_istft_ola.sv
// tb_istft_ola: table-driven and sequence checks of istft_ola with a timed expectation queue.
module tb_istft_ola;
    localparam int N = 256;
    localparam int H = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, ce, sync;
    logic signed [17:0] smp;
    logic               rdy, oce, osync, oerr;
    logic signed [15:0] osmp;
    logic               rdy0, oce0, osync0, oerr0;
    logic signed [15:0] osmp0;

    istft_ola dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sample(smp),
        .o_ready(rdy), .o_ce(oce), .o_sample(osmp), .o_sync(osync), .o_frame_err(oerr)
    );

    istft_ola #(.SHIFT(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sample(smp),
        .o_ready(rdy0), .o_ce(oce0), .o_sample(osmp0), .o_sync(osync0), .o_frame_err(oerr0)
    );

    typedef struct {int s3; int s0; bit sy; int d;} exp_t;
    typedef struct {int x; int f0_s3; int f1_s3; int f0_s0; int f1_s0;} vec_t;

    exp_t q[$];
    int cyc = 0;
    int n_chk = 0, n_fail = 0, oce_cnt = 0, err_cnt = 0, err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (oce || oce0) begin
            oce_cnt++;
            chk("ce_pair", int'(oce0), int'(oce));
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_oce: got o_ce=1 expected no output (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("sample_shift3", int'(osmp), e.s3);
                chk("sample_shift0", int'(osmp0), e.s0);
                chk("o_sync", int'(osync), int'(e.sy));
                chk("latency", cyc - e.d, 2);
            end
        end
        if (oerr) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input bit s, input bit emit, input int e3, input int e0);
        exp_t e;
        ce   = 1'b1;
        sync = s;
        smp  = 18'(x);
        if (emit) begin
            e = '{e3, e0, s, cyc};
            q.push_back(e);
        end
        tick();
        ce   = 1'b0;
        sync = 1'b0;
    endtask

    task automatic do_reset(input bit ce_in_clear);
        int n, snap;
        rst  = 1'b1;
        ce   = 1'b0;
        sync = 1'b0;
        // Samples accepted on the last edge before reset never reach the output.
        while (q.size() > 0 && q[$].d >= cyc - 1) void'(q.pop_back());
        tick();
        tick();
        chk("rst_o_ce", int'(oce), 0);
        chk("rst_o_sync", int'(osync), 0);
        chk("rst_o_frame_err", int'(oerr), 0);
        chk("rst_o_sample", int'(osmp), 0);
        chk("rst_o_ready", int'(rdy), 0);
        snap = oce_cnt;
        rst  = 1'b0;
        ce   = ce_in_clear;
        sync = ce_in_clear;
        smp  = 18'(1234);
        n = 0;
        while (rdy !== 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        ce   = 1'b0;
        sync = 1'b0;
        chk("clear_len", n, N);
        chk("oce_in_clear", oce_cnt - snap, 0);
        chk("queue_after_reset", q.size(), 0);
    endtask

    vec_t tbl[4];

    initial begin
        int snap, e0, d_err, sum;
        tbl[0] = '{1000, 125, 250, 1000, 2000};
        tbl[1] = '{-1001, -126, -251, -1001, -2002};
`ifdef ISTFT_SAT_EN
        tbl[2] = '{100000, 12500, 25000, 32767, 32767};
        tbl[3] = '{-100000, -12500, -25000, -32768, -32768};
`else
        tbl[2] = '{100000, 12500, 25000, -31072, 3392};
        tbl[3] = '{-100000, -12500, -25000, 31072, -3392};
`endif
        rst = 1'b1; ce = 1'b0; sync = 1'b0; smp = '0;
        @(posedge clk);
        #1;

        // Power-up clear with i_ce held high throughout
        do_reset(1'b1);

        // Samples before the first sync are dropped
        snap = oce_cnt;
        for (int i = 0; i < 20; i++) send(500, 1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        chk("dropped_before_sync", oce_cnt - snap, 0);

        // Constant-input frames from a cleared buffer
        for (int t = 0; t < 4; t++) begin
            do_reset(1'b0);
            e0 = err_cnt;
            for (int n = 0; n < N; n++)
                send(tbl[t].x, n == 0, n < H, tbl[t].f0_s3, tbl[t].f0_s0);
            for (int n = 0; n < N; n++)
                send(tbl[t].x, n == 0, n < H, tbl[t].f1_s3, tbl[t].f1_s0);
            repeat (4) tick();
            chk("table_drain", q.size(), 0);
            chk("table_no_frame_err", err_cnt - e0, 0);
        end

        // Ramp over three frames: base pointer wraps back to 0 on the third
        do_reset(1'b0);
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < N; n++) begin
                sum = (f == 0) ? n : n + 128 + n;
                send(n, n == 0, n < H, sum >>> 3, sum);
            end
        repeat (4) tick();
        chk("ramp_drain", q.size(), 0);

        // Misaligned sync at n=50 of the second frame
        do_reset(1'b0);
        e0 = err_cnt;
        for (int n = 0; n < N; n++) send(8, n == 0, n < H, 1, 8);
        for (int n = 0; n < 50; n++) send(8, n == 0, 1'b1, 2, 16);
        d_err = cyc;
        send(24, 1'b1, 1'b1, 3, 24);
        for (int n = 1; n < N; n++) send(24, 1'b0, n < H, 3, 24);
        chk("frame_err_pulses", err_cnt - e0, 1);
        chk("frame_err_timing", err_cyc - d_err, 1);
        for (int n = 0; n < 10; n++) send(24, n == 0, 1'b1, 6, 48);

        // Reset mid-frame with samples in flight
        do_reset(1'b0);
        for (int n = 0; n < H; n++) send(1000, n == 0, 1'b1, 125, 1000);
        repeat (4) tick();
        chk("post_reset_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
